// File: rtl/up_counter_4bit.sv
// up_counter_4bit: synchronous 4-bit binary up counter with asynchronous
// active-low reset, count enable, synchronous parallel load and a
// combinational terminal-count flag. The count leaves on four separate bit
// outputs, Q0 (LSB) to Q3 (MSB).
//
// Optional feature, macro UP_COUNTER_SYNC_CLR_EN:
//   defined   -> adds input clr (active-high, synchronous). Priority is
//                clr > load > en, and clr also forces tc low.
//   undefined -> no clr port exists; the counter behaves as described above.

module up_counter_4bit #(
   parameter int unsigned MAX_COUNT   = 15,  // terminal value, 1..15
   parameter int unsigned RESET_VALUE = 0    // value forced by rst_n, 0..15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       load,
   input  logic [3:0] d,
`ifdef UP_COUNTER_SYNC_CLR_EN
   input  logic       clr,
`endif
   output logic       Q0,
   output logic       Q1,
   output logic       Q2,
   output logic       Q3,
   output logic       tc
);

   localparam logic [3:0] MAX_C   = 4'(MAX_COUNT);
   localparam logic [3:0] RESET_C = 4'(RESET_VALUE);

   logic [3:0] count;
   logic [3:0] count_nxt;
   logic       clr_s;

`ifdef UP_COUNTER_SYNC_CLR_EN
   assign clr_s = clr;
`else
   assign clr_s = 1'b0;
`endif

   // Next-state rule. Any value at or above MAX_COUNT wraps to zero on an
   // enabled edge, so values above the terminal (reachable only through load
   // or RESET_VALUE) fall back into the counting range instead of running on.
   function automatic logic [3:0] next_count(
      input logic [3:0] cur,
      input logic       c,
      input logic       ld,
      input logic       e,
      input logic [3:0] dv
   );
      logic [3:0] nxt;
      nxt = cur;
      if (c) begin
         nxt = 4'd0;
      end else if (ld) begin
         nxt = dv;
      end else if (e) begin
         if (cur >= MAX_C) begin
            nxt = 4'd0;
         end else begin
            nxt = cur + 4'd1;
         end
      end
      return nxt;
   endfunction

   // Decode the next count from the current count and the control inputs
   always_comb begin
      count_nxt = next_count(count, clr_s, load, en, d);
   end

   // Count register: asynchronous reset discards any pending load or increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= RESET_C;
      end else begin
         count <= count_nxt;
      end
   end

   assign {Q3, Q2, Q1, Q0} = count;

   // tc flags the cycle whose edge wraps the counter; rst_n gating keeps it
   // low during reset even when RESET_VALUE equals MAX_COUNT.
   assign tc = rst_n & en & ~load & ~clr_s & (count == MAX_C);

endmodule

// File: tb/tb_up_counter_4bit.sv
// Scoreboard bench for up_counter_4bit: a default-parameter instance and a
// MAX_COUNT=9 instance. Stimulus pushes hand-computed expected tc (for the
// current cycle) and count (after the next edge) into a queue; a monitor
// process pops each entry and compares against the DUT outputs.

module tb_up_counter_4bit;

   logic       clk;
   logic       rst_n;
   logic       en_a, load_a, clr_a;
   logic [3:0] d_a;
   logic       en_b, load_b, clr_b;
   logic [3:0] d_b;
   logic       qa0, qa1, qa2, qa3, tc_a;
   logic       qb0, qb1, qb2, qb3, tc_b;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit         sel;      // 0: default instance, 1: MAX_COUNT=9 instance
      logic       exp_tc;   // tc while the inputs are applied
      logic [3:0] exp_q;    // count after the following rising edge
      string      name;
   } item_t;

   item_t sb[$];

   up_counter_4bit dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en_a),
      .load  (load_a),
      .d     (d_a),
`ifdef UP_COUNTER_SYNC_CLR_EN
      .clr   (clr_a),
`endif
      .Q0    (qa0),
      .Q1    (qa1),
      .Q2    (qa2),
      .Q3    (qa3),
      .tc    (tc_a)
   );

   up_counter_4bit #(.MAX_COUNT(9), .RESET_VALUE(0)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en_b),
      .load  (load_b),
      .d     (d_b),
`ifdef UP_COUNTER_SYNC_CLR_EN
      .clr   (clr_b),
`endif
      .Q0    (qb0),
      .Q1    (qb1),
      .Q2    (qb2),
      .Q3    (qb3),
      .tc    (tc_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs to the selected instance (the other holds)
   task automatic step(input bit sel, input logic e, input logic ld, input logic [3:0] dv,
                       input logic c, input logic exp_tc, input logic [3:0] exp_q,
                       input string name);
      item_t it;
      @(negedge clk);
      if (sel == 1'b0) begin
         en_a = e; load_a = ld; d_a = dv; clr_a = c;
         en_b = 1'b0; load_b = 1'b0; d_b = 4'd0; clr_b = 1'b0;
      end else begin
         en_b = e; load_b = ld; d_b = dv; clr_b = c;
         en_a = 1'b0; load_a = 1'b0; d_a = 4'd0; clr_a = 1'b0;
      end
      it.sel = sel; it.exp_tc = exp_tc; it.exp_q = exp_q; it.name = name;
      sb.push_back(it);
   endtask

   // Monitor: pops one expectation per cycle in which one is pending
   initial begin
      item_t it;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() != 0) begin
            it = sb.pop_front();
            if (it.sel == 1'b0) check({it.name, " tc"}, {3'b000, tc_a}, {3'b000, it.exp_tc});
            else                check({it.name, " tc"}, {3'b000, tc_b}, {3'b000, it.exp_tc});
            @(posedge clk);
            #1;
            if (it.sel == 1'b0) check({it.name, " q"}, {qa3, qa2, qa1, qa0}, it.exp_q);
            else                check({it.name, " q"}, {qb3, qb2, qb1, qb0}, it.exp_q);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      en_a = 1'b1; load_a = 1'b0; d_a = 4'd0; clr_a = 1'b0;
      en_b = 1'b1; load_b = 1'b0; d_b = 4'd0; clr_b = 1'b0;

      // Reset held for three edges with en=1
      repeat (3) @(posedge clk);
      #1;
      check("reset_hold_a q", {qa3, qa2, qa1, qa0}, 4'b0000);
      check("reset_hold_a tc", {3'b000, tc_a}, 4'b0000);
      check("reset_hold_b q", {qb3, qb2, qb1, qb0}, 4'b0000);
      check("reset_hold_b tc", {3'b000, tc_b}, 4'b0000);
      @(negedge clk);
      en_a = 1'b0; en_b = 1'b0;
      rst_n = 1'b1;

      // Free count, 20 edges: tc only while count is 1111
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, (i % 16) == 15, 4'((i + 1) % 16), "free_count");
      end
      // count is now 0100
      step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'b0101, "to_0101");
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'b0101, "enable_hold");
      end
      step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'b0110, "resume");

      // Asynchronous reset mid-cycle at count 0110, en still high
      @(negedge clk);
      en_a = 1'b1;
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset q", {qa3, qa2, qa1, qa0}, 4'b0000);
      check("async_reset tc", {3'b000, tc_a}, 4'b0000);
      @(posedge clk);
      #1;
      check("reset_held q", {qa3, qa2, qa1, qa0}, 4'b0000);
      @(negedge clk);
      en_a = 1'b0;
      rst_n = 1'b1;

      // Load priority over enable, load of MAX_COUNT then wrap
      step(1'b0, 1'b1, 1'b1, 4'b1010, 1'b0, 1'b0, 4'b1010, "load_1010");
      step(1'b0, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b1111, "load_1111");
      step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, "wrap_after_load");
      step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, "count_after_wrap");
      step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b1111, "load_en0");
      step(1'b0, 1'b1, 1'b1, 4'b0101, 1'b0, 1'b0, 4'b0101, "tc_masked_by_load");
      step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0101, "hold_en0");

      // MAX_COUNT=9 instance: 0..9 then wrap
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, i == 9, 4'((i + 1) % 10), "mod10_count");
      end
      step(1'b1, 1'b1, 1'b1, 4'b1100, 1'b0, 1'b0, 4'b1100, "mod10_load_1100");
      step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, "mod10_above_max");
      step(1'b1, 1'b0, 1'b1, 4'b1001, 1'b0, 1'b0, 4'b1001, "mod10_load_9");
      step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1001, "mod10_hold_9");
      step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, "mod10_wrap_9");

`ifdef UP_COUNTER_SYNC_CLR_EN
      // Synchronous clear beats load and enable
      step(1'b0, 1'b0, 1'b1, 4'b0111, 1'b0, 1'b0, 4'b0111, "clr_setup");
      step(1'b0, 1'b1, 1'b1, 4'b0011, 1'b1, 1'b0, 4'b0000, "clr_over_load");
      step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, "clr_resume1");
      step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0010, "clr_resume2");
      step(1'b0, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b1111, "clr_load_max");
      step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, "clr_masks_tc");
`endif

      // Drain the scoreboard within a bounded number of cycles
      @(negedge clk);
      en_a = 1'b0; load_a = 1'b0; en_b = 1'b0; load_b = 1'b0;
      clr_a = 1'b0; clr_b = 1'b0;
      for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
